// File: rtl/toast_inst_classifier.sv
// Streaming RV32I classifier: NOP/LUI/OTHER/ILLEGAL decode with one output register stage.
// Optional first-ILLEGAL PC capture is enabled by defining TOAST_CLS_ILL_CAPTURE_EN.
module toast_inst_classifier #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PC_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inst_valid,
  output logic              o_inst_ready,
  input  logic [31:0]       i_inst,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_cls_valid,
  input  logic              i_cls_ready,
  output logic [1:0]        o_cls,
  output logic [PC_W-1:0]   o_pc,
  output logic [4:0]        o_rd,
  output logic [31:0]       o_imm,
  input  logic              i_clear,
  output logic [CNT_W-1:0]  o_nop_cnt,
  output logic [CNT_W-1:0]  o_lui_cnt,
  output logic [CNT_W-1:0]  o_other_cnt,
  output logic [CNT_W-1:0]  o_ill_cnt,
  output logic              o_ill_seen,
  output logic [PC_W-1:0]   o_ill_pc
);

  localparam logic [1:0] ClsNop   = 2'd0;
  localparam logic [1:0] ClsLui   = 2'd1;
  localparam logic [1:0] ClsOther = 2'd2;
  localparam logic [1:0] ClsIll   = 2'd3;

  logic        fire;
  logic        legal_op;
  logic [1:0]  cls_d;
  logic [4:0]  rd_d;
  logic [31:0] imm_d;

  assign o_inst_ready = !o_cls_valid || i_cls_ready;
  assign fire         = i_inst_valid && o_inst_ready;

  always_comb begin
    legal_op = 1'b0;
    case (i_inst[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  always_comb begin
    cls_d = ClsOther;
    rd_d  = 5'd0;
    imm_d = 32'd0;
    if (i_inst[1:0] != 2'b11 || !legal_op) begin
      cls_d = ClsIll;
    end else if (i_inst == 32'h0000_0013) begin
      cls_d = ClsNop;
    end else if (i_inst[6:0] == 7'h37) begin
      cls_d = ClsLui;
      rd_d  = i_inst[11:7];
      imm_d = {i_inst[31:12], 12'h000};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cls_valid <= 1'b0;
      o_cls       <= ClsNop;
      o_pc        <= '0;
      o_rd        <= '0;
      o_imm       <= '0;
    end else if (fire) begin
      o_cls_valid <= 1'b1;
      o_cls       <= cls_d;
      o_pc        <= i_pc;
      o_rd        <= rd_d;
      o_imm       <= imm_d;
    end else if (i_cls_ready) begin
      o_cls_valid <= 1'b0;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_nop_cnt   <= '0;
      o_lui_cnt   <= '0;
      o_other_cnt <= '0;
      o_ill_cnt   <= '0;
    end else if (i_clear) begin
      o_nop_cnt   <= '0;
      o_lui_cnt   <= '0;
      o_other_cnt <= '0;
      o_ill_cnt   <= '0;
    end else if (fire) begin
      unique case (cls_d)
        ClsNop:   o_nop_cnt   <= sat_inc(o_nop_cnt);
        ClsLui:   o_lui_cnt   <= sat_inc(o_lui_cnt);
        ClsOther: o_other_cnt <= sat_inc(o_other_cnt);
        default:  o_ill_cnt   <= sat_inc(o_ill_cnt);
      endcase
    end
  end

`ifdef TOAST_CLS_ILL_CAPTURE_EN
  // Only the first ILLEGAL word since reset/clear is captured.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ill_seen <= 1'b0;
      o_ill_pc   <= '0;
    end else if (i_clear) begin
      o_ill_seen <= 1'b0;
      o_ill_pc   <= '0;
    end else if (fire && cls_d == ClsIll && !o_ill_seen) begin
      o_ill_seen <= 1'b1;
      o_ill_pc   <= i_pc;
    end
  end
`else
  assign o_ill_seen = 1'b0;
  assign o_ill_pc   = '0;
`endif

endmodule
